// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file write path: priority encoding and default widths.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_DEPTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    // Round-robin priority: which requester wins when both are valid.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: set on issue, cleared on register-file write.
module regfile_scoreboard #(
    parameter int unsigned ADDR_DEPTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_valid,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [ADDR_DEPTH-1:0] busy
);

    logic [ADDR_DEPTH-1:0] busy_d;

    // Set is applied after clear so a same-edge reissue keeps the entry busy; x0 never tracked.
    always_comb begin
        busy_d = busy;
        for (int i = 1; i < ADDR_DEPTH; i++) begin
            if (clr_valid && clr_addr == ADDR_WIDTH'(i)) busy_d[i] = 1'b0;
            if (set_valid && set_addr == ADDR_WIDTH'(i)) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter driving a registered register-file write port,
// with a pending-write scoreboard.
module regfile_write_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_DEPTH = ADDR_DEPTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  WE3,
    output logic [ADDR_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic [ADDR_DEPTH-1:0] busy
);

    pri_e                  pri_q;
    logic                  grant0;
    logic                  grant1;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Grants depend only on valids and priority, never on the write port.
    always_comb begin
        grant0   = req0_valid && (!req1_valid || pri_q == PRI0);
        grant1   = req1_valid && !grant0;
        win_addr = grant0 ? req0_addr : req1_addr;
        win_data = grant0 ? req0_data : req1_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // x0 requests are accepted and rotate priority, but leave the write port idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI0;
            WE3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
        end else begin
            WE3 <= 1'b0;
            if (grant0 || grant1) begin
                pri_q <= grant0 ? PRI1 : PRI0;
                if (win_addr != '0) begin
                    WE3 <= 1'b1;
                    A3  <= win_addr;
                    WD3 <= win_data;
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_DEPTH(ADDR_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_valid(iss_valid),
        .set_addr (iss_rd),
        .clr_valid(WE3),
        .clr_addr (A3),
        .busy     (busy)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed test for regfile_write_arbiter: reset, arbitration, x0 handling, scoreboard.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] busy;

    int n_cmp;
    int n_bad;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [4:0] exp_a3 [4];
        logic       exp_r0 [3];
        exp_a3 = '{5'd1, 5'd2, 5'd1, 5'd2};
        exp_r0 = '{1'b0, 1'b1, 1'b0};
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        iss_valid = 1'b0; iss_rd = '0;

        // Reset state, ready follows valid during reset
        #2;
        check("rst_we3", 64'(WE3), 64'h0);
        check("rst_a3", 64'(A3), 64'h0);
        check("rst_wd3", 64'(WD3), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", 64'(req0_ready), 64'h1);
        check("rst_ready1", 64'(req1_ready), 64'h0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Contention: both valid for 4 transfers, priority starts at PRI0
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        #1;
        check("cont_ready0_0", 64'(req0_ready), 64'h1);
        check("cont_ready1_0", 64'(req1_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_we3", 64'(WE3), 64'h1);
            check("cont_a3", 64'(A3), 64'(exp_a3[k]));
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                #1;
                check("cont_ready0", 64'(req0_ready), 64'(exp_r0[k]));
                check("cont_ready1", 64'(req1_ready), 64'(!exp_r0[k]));
            end
        end

        // Idle: write port drops, A3/WD3 hold
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_we3", 64'(WE3), 64'h0);
            check("idle_a3", 64'(A3), 64'h2);
            check("idle_wd3", 64'(WD3), 64'h22);
        end

        // Priority still PRI0 after idle: req0 wins, req1 held then granted
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h33333333;
        #1;
        check("pri_ready0", 64'(req0_ready), 64'h1);
        check("pri_ready1", 64'(req1_ready), 64'h0);
        tick();
        check("single_we3", 64'(WE3), 64'h1);
        check("single_a3", 64'(A3), 64'h5);
        check("single_wd3", 64'(WD3), 64'hDEADBEEF);
        req0_valid = 1'b0;
        #1;
        check("held_ready1", 64'(req1_ready), 64'h1);
        tick();
        check("held_a3", 64'(A3), 64'h3);
        check("held_wd3", 64'(WD3), 64'h33333333);
        req1_valid = 1'b0;

        // x0 write: accepted, discarded; issue to x0 ignored
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        check("x0_ready1", 64'(req1_ready), 64'h1);
        tick();
        req1_valid = 1'b0; iss_valid = 1'b0;
        check("x0_we3", 64'(WE3), 64'h0);
        check("x0_a3", 64'(A3), 64'h3);
        check("x0_wd3", 64'(WD3), 64'h33333333);
        check("x0_busy", 64'(busy), 64'h0);

        // Scoreboard set and clear
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        check("sb_set", 64'(busy), 64'h80);
        iss_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        #1;
        check("sb_ready0", 64'(req0_ready), 64'h1);
        tick();
        req0_valid = 1'b0;
        check("sb_we3", 64'(WE3), 64'h1);
        check("sb_busy_pend", 64'(busy), 64'h80);
        tick();
        check("sb_clear", 64'(busy), 64'h0);

        // Scoreboard: reissue on the clearing edge keeps the bit set
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h78;
        tick();
        req0_valid = 1'b0;
        check("sb2_we3", 64'(WE3), 64'h1);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("sb2_busy", 64'(busy), 64'h80);

        // Mid-operation reset with a write on the port (priority is PRI1 after this grant)
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        req0_valid = 1'b0; iss_valid = 1'b0;
        check("mr_we3_pre", 64'(WE3), 64'h1);
        check("mr_busy_pre", 64'(busy), 64'h280);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_we3", 64'(WE3), 64'h0);
        check("mr_a3", 64'(A3), 64'h0);
        check("mr_wd3", 64'(WD3), 64'h0);
        check("mr_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_post_we3", 64'(WE3), 64'h0);
        check("mr_post_busy", 64'(busy), 64'h0);

        // Resume: priority back to PRI0
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h88;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
        #1;
        check("res_ready0", 64'(req0_ready), 64'h1);
        check("res_ready1", 64'(req1_ready), 64'h0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("res_we3", 64'(WE3), 64'h1);
        check("res_a3", 64'(A3), 64'h8);
        check("res_wd3", 64'(WD3), 64'h88);
        tick();
        check("res_idle_we3", 64'(WE3), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_DEPTH, default 32, meaning number of architectural registers.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  write request from requester 0 (ALU) / 1 (load unit).
REQ-007 SHALL have ports req0_addr / req1_addr  input  ADDR_WIDTH  destination register.
REQ-008 SHALL have ports req0_data / req1_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle (grant).
REQ-010 SHALL have ports iss_valid  input  1 and iss_rd  input  ADDR_WIDTH  instruction issue reserving a destination.
REQ-011 SHALL have ports WE3  output  1, A3  output  ADDR_WIDTH, WD3  output  DATA_WIDTH  registered register-file write port.
REQ-012 SHALL have port busy  output  ADDR_DEPTH  per-register pending-write scoreboard.

Function
REQ-013 SHALL hold a 1-bit round-robin priority state: PRI0 (requester 0 favoured) or PRI1.
REQ-014 SHALL grant at most one requester per cycle; sole valid requester is granted; both valid -> favoured one granted.
REQ-015 SHALL drive reqN_ready combinationally = grant to N; ready never asserted without matching valid.
REQ-016 SHALL complete a transfer when reqN_valid && reqN_ready on a rising edge; requester holds addr/data stable while valid and not ready.
REQ-017 SHALL move priority on every transfer to the non-granted requester (grant 0 -> PRI1, grant 1 -> PRI0); no transfer -> priority unchanged.
REQ-018 SHALL register the granted request: next cycle WE3=1, A3=addr, WD3=data; otherwise WE3=0 next cycle (one-cycle latency, one write per cycle sustained).
REQ-019 SHALL accept requests with addr 0 normally but force WE3=0 for them (x0 writes discarded).
REQ-020 SHALL set busy[iss_rd] on a rising edge with iss_valid=1 and iss_rd!=0; busy[0] SHALL always read 0.
REQ-021 SHALL clear busy[A3] on the rising edge where WE3=1 (the same edge the register file stores the value).
REQ-022 SHALL, on simultaneous set and clear of the same index, leave busy set (new issue wins).
REQ-023 SHALL hold A3/WD3 at their last values when WE3=0.

Reset
REQ-024 SHALL on rst_n low immediately force WE3=0, A3=0, WD3=0, busy=0, priority=PRI0; reqN_ready follows from valid inputs.
REQ-025 SHALL discard any registered-but-uncommitted write when reset asserts mid-operation; no write appears after deassertion.
REQ-026 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place priority state encoding (PRI0, PRI1) and default widths in shared package riscv_pkg.
REQ-028 SHALL be a single module; scoreboard logic MAY be a sub-module named regfile_scoreboard.
REQ-029 SHALL contain no combinational path from WE3/A3/WD3 back to reqN_ready.

Verification
REQ-030 Reset: rst_n=0 mid-cycle with WE3=1 -> WE3=0, busy=0 immediately; no write after release.
REQ-031 Single requester: req0 valid, addr 5, data 0xDEADBEEF -> req0_ready=1 same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-032 Contention: both valid 4 cycles, addr 1/2 -> grants 0,1,0,1; WE3 sequence A3=1,2,1,2; each requester held until ready.
REQ-033 x0: req1 valid addr 0 data 0x1234 -> req1_ready=1, WE3 stays 0, busy[0]=0.
REQ-034 Scoreboard: iss_valid rd=7 -> busy[7]=1; req0 write to 7 -> busy[7] clears on WE3 edge; iss rd=7 on that same edge -> busy[7] stays 1.
REQ-035 Idle: no valid for 3 cycles after a grant to 1 -> priority stays PRI0, WE3=0, A3/WD3 unchanged.
